configuration_cpu_cpu_debug_mem_arbiter: RTL and testbench
==========================================================

CONFIGURATION_CPU_CPU_DEBUG_MEM_ARBITER -- requirements
Module: configuration_cpu_cpu_debug_mem_arbiter

Interface
REQ-001 Parameter RAM_AW, default 8, word-address width of the shared OCI RAM; the data width SHALL be fixed at 32.
REQ-002 The ports SHALL be as follows (clock and reset first):
- clk  in  1  sole clock for every register.
- reset  in  1  asynchronous, active-high.
- jdo  in  38  JTAG debug data, already synchronised to clk.
- take_action_ocimem_a  in  1  1-cycle strobe: load the JTAG address, optionally request a read.
- take_no_action_ocimem_a  in  1  1-cycle strobe: read at the current JTAG address.
- take_action_ocimem_b  in  1  1-cycle strobe: write the JTAG data.
- av_address  in  RAM_AW  Avalon host word address.
- av_read  in  1  Avalon read request.
- av_write  in  1  Avalon write request.
- av_writedata  in  32  Avalon write data.
- av_readdata  out  32  Avalon read data.
- av_waitrequest  out  1  Avalon stall.
- ram_addr  out  RAM_AW  shared RAM address.
- ram_wren  out  1  shared RAM write enable.
- ram_wdata  out  32  shared RAM write data.
- ram_rdata  in  32  shared RAM read data, 1-cycle latency.
- MonDReg  out  32  last JTAG read result.
- monitor_ready  out  1  JTAG access complete.

Function
REQ-003 On take_action_ocimem_a: jtag_addr <= jdo[RAM_AW+1:2]; jtag_rd_pend is set if jdo[35]=1.
REQ-004 On take_no_action_ocimem_a: jtag_rd_pend is set and jtag_addr is unchanged.
REQ-005 On take_action_ocimem_b: jtag_wdata <= jdo[34:3] and jtag_wr_pend is set.
REQ-006 A strobe on an already-pending request SHALL overwrite it; the latest strobe wins and the earlier request is lost.
REQ-007 Any ocimem strobe SHALL clear monitor_ready in the next cycle.
REQ-008 The FSM SHALL have the states IDLE, J_RD and A_RD.
- In IDLE, at most one RAM access SHALL be issued per cycle.
- A write completes in its issue cycle (ram_wren=1).
- A read issues in IDLE, moves to J_RD or A_RD, and is captured there, then returns to IDLE.
REQ-009 A JTAG request exists if jtag_wr_pend or jtag_rd_pend is set; within JTAG, a write SHALL be served before a read.
REQ-010 An Avalon request exists if av_read or av_write is high; if both are high, the access SHALL be treated as a write.
REQ-011 Two-way round-robin arbitration:
- On contention, the grant SHALL go to the requester not granted last.
- last_grant resets to Avalon, so JTAG wins the first contention.
- The worst-case wait for either requester SHALL be no more than 3 cycles.
REQ-012 av_waitrequest SHALL equal (av_read|av_write) AND NOT done.
- done = Avalon write issued this cycle, or A_RD capture cycle.
- In A_RD, av_readdata SHALL be loaded with ram_rdata and is valid when av_waitrequest=0.
REQ-013 JTAG read capture (J_RD): MonDReg <= ram_rdata, monitor_ready <= 1 next cycle. A JTAG write SHALL set monitor_ready next cycle and leave MonDReg unchanged.
REQ-014 The matching pend flag SHALL clear when its access is issued; a strobe in that same cycle SHALL set the flag again.
REQ-015 When idle: ram_wren=0, ram_addr holds its last value, ram_wdata is don't-care.

Reset
REQ-016 While reset=1:
- state=IDLE, all pend flags=0, jtag_addr=0, jtag_wdata=0, last_grant=Avalon.
- MonDReg=0, av_readdata=0, monitor_ready=0, ram_wren=0, ram_addr=0.
REQ-017 Reset asserted mid-read SHALL abort the read with no capture. After reset releases, a held Avalon request SHALL be re-arbitrated from IDLE.

Configuration
REQ-018 With DEBUG_MEM_ARB_AUTOINC_EN defined:
- jtag_addr SHALL increment by 1, modulo 2^RAM_AW, after each completed JTAG access.
- A take_action_ocimem_a in the same cycle as an increment SHALL win, and the address is loaded.
Without the macro, jtag_addr changes only on take_action_ocimem_a.

Structure
REQ-019 Package configuration_cpu_cpu_debug_pkg SHALL hold:
- the state enum;
- JDO_RD_REQ_BIT=35, JDO_WDATA_LSB=3, JDO_ADDR_LSB=2;
- the grant-owner constants.
REQ-020 One sub-module, configuration_cpu_cpu_debug_rr_arb2, SHALL implement the two-requester round-robin arbiter with its last_grant register.

Verification
REQ-021 A bench SHALL cover the following directed scenarios:
- take_action_ocimem_a with jdo[9:2]=8'h10 and jdo[35]=1, RAM[0x10]=32'hDEADBEEF -> ram_addr=0x10 next cycle; MonDReg=DEADBEEF and monitor_ready=1 three cycles after the strobe.
- take_action_ocimem_b with jdo[34:3]=32'h12345678 at addr 0x10 -> one ram_wren pulse with ram_wdata=12345678, then monitor_ready=1; MonDReg unchanged.
- av_read at 0x20 held continuously while JTAG strobes every 2 cycles -> grants alternate and av_waitrequest is never high for more than 3 consecutive cycles; av_readdata=RAM[0x20].
- av_read and av_write both high at 0x05 with data 32'hA5A5A5A5 -> write issued, RAM[0x05]=A5A5A5A5, no read.
- reset pulsed in the J_RD cycle -> MonDReg=0, monitor_ready=0, no later ram_wren.
- With AUTOINC, three take_no_action_ocimem_a strobes from addr 0xFE -> reads at 0xFE, 0xFF, 0x00. Without AUTOINC, all three reads at 0xFE.

Source files
------------

// File: rtl/configuration_cpu_cpu_debug_pkg.sv
// rtl/configuration_cpu_cpu_debug_pkg.sv - shared types and constants for the debug memory arbiter
// Holds the arbiter FSM state enum, the jdo field positions and the grant-owner encodings.
package configuration_cpu_cpu_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_J_RD = 2'd1,
        ST_A_RD = 2'd2
    } state_t;

    localparam int JDO_RD_REQ_BIT = 35;
    localparam int JDO_WDATA_LSB  = 3;
    localparam int JDO_ADDR_LSB   = 2;

    localparam logic OWNER_AV   = 1'b0;
    localparam logic OWNER_JTAG = 1'b1;

endpackage

// File: rtl/configuration_cpu_cpu_debug_rr_arb2.sv
// rtl/configuration_cpu_cpu_debug_rr_arb2.sv - two-requester round-robin arbiter
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enable              grants may only be issued while high
//   req_jtag, req_av    request lines
//   gnt_jtag, gnt_av    one-hot (or zero) combinational grants
// last_grant remembers the owner of the most recent grant; on contention the
// other requester wins. It resets to the Avalon side so JTAG wins first.
module configuration_cpu_cpu_debug_rr_arb2
    import configuration_cpu_cpu_debug_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req_jtag,
    input  logic req_av,
    output logic gnt_jtag,
    output logic gnt_av
);

    logic last_grant;

    always_comb begin
        gnt_jtag = 1'b0;
        gnt_av   = 1'b0;
        if (enable) begin
            if (req_jtag && req_av) begin
                gnt_jtag = (last_grant == OWNER_AV);
                gnt_av   = (last_grant == OWNER_JTAG);
            end else begin
                gnt_jtag = req_jtag;
                gnt_av   = req_av;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= OWNER_AV;
        end else if (gnt_jtag) begin
            last_grant <= OWNER_JTAG;
        end else if (gnt_av) begin
            last_grant <= OWNER_AV;
        end
    end

endmodule

// File: rtl/configuration_cpu_cpu_debug_mem_arbiter.sv
// rtl/configuration_cpu_cpu_debug_mem_arbiter.sv - JTAG / Avalon arbiter for the shared OCI RAM
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   jdo, take_*_ocimem_*            JTAG debug data and one-cycle command strobes
//   av_*                            Avalon slave (read/write, waitrequest, readdata)
//   ram_addr/ram_wren/ram_wdata     shared RAM command, ram_rdata returns one cycle later
//   MonDReg, monitor_ready          JTAG read result and access-complete flag
// Optional feature: define DEBUG_MEM_ARB_AUTOINC_EN to post-increment the JTAG
// address after every completed JTAG access.
module configuration_cpu_cpu_debug_mem_arbiter
    import configuration_cpu_cpu_debug_pkg::*;
#(
    parameter int RAM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [RAM_AW-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_wren,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready
);

    state_t            state;
    logic              jtag_rd_pend;
    logic              jtag_wr_pend;
    logic [RAM_AW-1:0] jtag_addr;
    logic [31:0]       jtag_wdata;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [31:0]       av_readdata_q;

    logic gnt_jtag, gnt_av;
    logic j_wr_issue, j_rd_issue, a_wr_issue, a_rd_issue;
    logic j_done, done, strobe_any;

    // jdo bits outside the address, data and read-request fields carry nothing here
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    configuration_cpu_cpu_debug_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .enable   ((state == ST_IDLE) && !reset),
        .req_jtag (jtag_rd_pend | jtag_wr_pend),
        .req_av   (av_read | av_write),
        .gnt_jtag (gnt_jtag),
        .gnt_av   (gnt_av)
    );

    // A JTAG grant serves the pending write before the pending read; an Avalon
    // grant with both read and write high is a write.
    assign j_wr_issue = gnt_jtag & jtag_wr_pend;
    assign j_rd_issue = gnt_jtag & ~jtag_wr_pend;
    assign a_wr_issue = gnt_av & av_write;
    assign a_rd_issue = gnt_av & ~av_write;

    assign j_done     = j_wr_issue | (state == ST_J_RD);
    assign done       = a_wr_issue | (state == ST_A_RD);
    assign strobe_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    always_comb begin
        ram_wren  = j_wr_issue | a_wr_issue;
        ram_wdata = j_wr_issue ? jtag_wdata : av_writedata;
        if (gnt_jtag) begin
            ram_addr = jtag_addr;
        end else if (gnt_av) begin
            ram_addr = av_address;
        end else begin
            ram_addr = ram_addr_q;
        end
    end

    assign av_waitrequest = (av_read | av_write) & ~done;
    // Read data is presented in the same cycle waitrequest drops, then held.
    assign av_readdata    = (state == ST_A_RD) ? ram_rdata : av_readdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            jtag_rd_pend  <= 1'b0;
            jtag_wr_pend  <= 1'b0;
            jtag_addr     <= '0;
            jtag_wdata    <= '0;
            ram_addr_q    <= '0;
            av_readdata_q <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
        end else begin
            if (gnt_jtag || gnt_av) begin
                ram_addr_q <= ram_addr;
            end

            case (state)
                ST_IDLE: begin
                    if (j_rd_issue) begin
                        state <= ST_J_RD;
                    end else if (a_rd_issue) begin
                        state <= ST_A_RD;
                    end
                end
                ST_J_RD: begin
                    MonDReg <= ram_rdata;
                    state   <= ST_IDLE;
                end
                ST_A_RD: begin
                    av_readdata_q <= ram_rdata;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Issue clears the flag; a strobe in the same cycle re-arms it.
            if (j_wr_issue) begin
                jtag_wr_pend <= 1'b0;
            end
            if (j_rd_issue) begin
                jtag_rd_pend <= 1'b0;
            end
            if (take_action_ocimem_b) begin
                jtag_wr_pend <= 1'b1;
                jtag_wdata   <= jdo[JDO_WDATA_LSB +: 32];
            end
            if ((take_action_ocimem_a && jdo[JDO_RD_REQ_BIT]) || take_no_action_ocimem_a) begin
                jtag_rd_pend <= 1'b1;
            end

            if (strobe_any) begin
                monitor_ready <= 1'b0;
            end else if (j_done) begin
                monitor_ready <= 1'b1;
            end

            if (take_action_ocimem_a) begin
                jtag_addr <= jdo[JDO_ADDR_LSB +: RAM_AW];
            end
`ifdef DEBUG_MEM_ARB_AUTOINC_EN
            else if (j_done) begin
                jtag_addr <= jtag_addr + RAM_AW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_configuration_cpu_cpu_debug_mem_arbiter.sv
// tb/tb_configuration_cpu_cpu_debug_mem_arbiter.sv - self-checking bench for the debug memory arbiter
module tb_configuration_cpu_cpu_debug_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [7:0]  av_address = '0;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready;

    int checks = 0;
    int errors = 0;

    configuration_cpu_cpu_debug_mem_arbiter #(.RAM_AW(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready)
    );

    always #5 clk = ~clk;

    // Environment RAM with one-cycle read latency
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pending-request bookkeeping, a shadow memory and a
    // count of which read is returning data in the current cycle.
    logic [31:0] ref_mem [0:255];
    bit          m_rd_pend, m_wr_pend, m_last_jtag, m_ready;
    logic [7:0]  m_addr, m_hold, m_rd_addr;
    logic [31:0] m_wdata, m_mon, m_avrd;
    int          m_busy;  // 0 none, 1 JTAG read data returning, 2 Avalon read data returning

    always @(negedge clk) begin : model
        bit          jreq, areq, gj, ga, xdone, xwren, jdone, a_stb;
        logic [7:0]  xaddr;
        logic [31:0] xwdata, xavrd;
        int          nbusy;
        if (reset) begin
            check("rst_wren", ram_wren, 0);
            check("rst_addr", ram_addr, 0);
            check("rst_mondreg", MonDReg, 0);
            check("rst_readdata", av_readdata, 0);
            check("rst_ready", monitor_ready, 0);
            m_rd_pend = 0; m_wr_pend = 0; m_last_jtag = 0; m_ready = 0;
            m_addr = 0; m_hold = 0; m_rd_addr = 0; m_wdata = 0; m_mon = 0; m_avrd = 0;
            m_busy = 0;
        end else begin
            jreq = m_rd_pend || m_wr_pend;
            areq = av_read || av_write;
            gj = 0; ga = 0; xdone = 0; xwren = 0; jdone = 0;
            xaddr = m_hold; xwdata = 0;
            if (m_busy == 0) begin
                if (jreq && areq) begin
                    gj = !m_last_jtag;
                    ga = m_last_jtag;
                end else begin
                    gj = jreq;
                    ga = areq;
                end
            end
            if (gj) begin
                xaddr = m_addr;
                if (m_wr_pend) begin xwren = 1; xwdata = m_wdata; jdone = 1; end
            end
            if (ga) begin
                xaddr = av_address;
                if (av_write) begin xwren = 1; xwdata = av_writedata; xdone = 1; end
            end
            xavrd = m_avrd;
            if (m_busy == 2) begin xdone = 1; xavrd = ref_mem[m_rd_addr]; end

            check("ram_wren", ram_wren, xwren);
            check("ram_addr", ram_addr, xaddr);
            if (xwren) check("ram_wdata", ram_wdata, xwdata);
            check("av_waitrequest", av_waitrequest, areq && !xdone);
            check("av_readdata", av_readdata, xavrd);
            check("MonDReg", MonDReg, m_mon);
            check("monitor_ready", monitor_ready, m_ready);

            if (xwren) ref_mem[xaddr] = xwdata;
            if (m_busy == 1) begin m_mon = ref_mem[m_rd_addr]; jdone = 1; end
            m_avrd = xavrd;
            nbusy = 0;
            if (gj && !m_wr_pend) begin nbusy = 1; m_rd_addr = m_addr; end
            if (ga && !av_write) begin nbusy = 2; m_rd_addr = av_address; end
            m_busy = nbusy;
            if (gj || ga) begin m_hold = xaddr; m_last_jtag = gj; end
            if (gj) begin
                if (m_wr_pend) m_wr_pend = 0; else m_rd_pend = 0;
            end
            if (take_action_ocimem_b) begin m_wr_pend = 1; m_wdata = jdo[34:3]; end
            a_stb = take_action_ocimem_a;
            if ((a_stb && jdo[35]) || take_no_action_ocimem_a) m_rd_pend = 1;
            if (a_stb || take_no_action_ocimem_a || take_action_ocimem_b) m_ready = 0;
            else if (jdone) m_ready = 1;
            if (a_stb) m_addr = jdo[9:2];
`ifdef DEBUG_MEM_ARB_AUTOINC_EN
            else if (jdone) m_addr = m_addr + 8'd1;
`endif
        end
    end

    initial begin
        int run, maxrun, wr_seen;
        bit av_acc;
        logic [7:0] exp_addr [0:2];

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
        end
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hCAFEF00D;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mondreg", MonDReg, 32'h0);
        check("reset_ready", monitor_ready, 0);
        check("reset_ram_addr", ram_addr, 8'h00);
        tick();
        reset = 1'b0;
        tick();

        // JTAG read of 0x10
        jdo = '0; jdo[35] = 1'b1; jdo[9:2] = 8'h10;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        @(negedge clk);
        check("s1_ram_addr", ram_addr, 8'h10);
        tick(); tick();
        @(negedge clk);
        check("s1_mondreg", MonDReg, 32'hDEADBEEF);
        check("s1_ready", monitor_ready, 1);

        // JTAG write of 0x12345678 at 0x10
        jdo = '0; jdo[9:2] = 8'h10;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        jdo = '0; jdo[34:3] = 32'h12345678;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        check("s2_wren", ram_wren, 1);
        check("s2_addr", ram_addr, 8'h10);
        check("s2_wdata", ram_wdata, 32'h12345678);
        tick();
        @(negedge clk);
        check("s2_wren_pulse", ram_wren, 0);
        check("s2_ready", monitor_ready, 1);
        check("s2_mondreg", MonDReg, 32'hDEADBEEF);
        check("s2_mem", mem[8'h10], 32'h12345678);

        // Held Avalon read against JTAG strobes every two cycles
        av_address = 8'h20; av_read = 1'b1; run = 0; maxrun = 0;
        for (int i = 0; i < 24; i++) begin
            take_no_action_ocimem_a = (i % 2 == 0);
            @(negedge clk);
            if (av_waitrequest) run++;
            else begin
                run = 0;
                check("s3_readdata", av_readdata, 32'hCAFEF00D);
            end
            if (run > maxrun) maxrun = run;
            tick();
        end
        take_no_action_ocimem_a = 1'b0; av_read = 1'b0;
        check("s3_max_wait", maxrun <= 3, 1);
        repeat (4) tick();

        // Read and write together is a write
        av_address = 8'h05; av_read = 1'b1; av_write = 1'b1; av_writedata = 32'hA5A5A5A5;
        @(negedge clk);
        check("s4_wren", ram_wren, 1);
        check("s4_addr", ram_addr, 8'h05);
        check("s4_wait", av_waitrequest, 0);
        tick();
        av_read = 1'b0; av_write = 1'b0;
        @(negedge clk);
        check("s4_no_read", av_readdata, 32'hCAFEF00D);
        check("s4_mem", mem[8'h05], 32'hA5A5A5A5);
        tick();

        // Reset in the J_RD cycle
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("s5_mondreg", MonDReg, 32'h0);
        check("s5_ready", monitor_ready, 0);
        tick();
        reset = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ram_wren) wr_seen++;
            tick();
        end
        check("s5_no_wren", wr_seen, 0);

        // Three reads from 0xFE
`ifdef DEBUG_MEM_ARB_AUTOINC_EN
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00;
`else
        exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFE; exp_addr[2] = 8'hFE;
`endif
        jdo = '0; jdo[9:2] = 8'hFE;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            take_no_action_ocimem_a = 1'b1;
            tick();
            take_no_action_ocimem_a = 1'b0;
            @(negedge clk);
            check("s6_read_addr", ram_addr, exp_addr[k]);
            tick(); tick();
        end

        // Randomised traffic, Avalon master holds a request until accepted
        av_acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ((!av_read && !av_write) || av_acc) begin
                av_read = 1'b0; av_write = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    av_address = 8'($urandom);
                    av_writedata = $urandom;
                    case ($urandom_range(0, 2))
                        0: av_read = 1'b1;
                        1: av_write = 1'b1;
                        default: begin av_read = 1'b1; av_write = 1'b1; end
                    endcase
                end
            end
            jdo = {6'($urandom), $urandom};
            take_action_ocimem_a    = ($urandom_range(0, 5) == 0);
            take_no_action_ocimem_a = ($urandom_range(0, 5) == 0);
            take_action_ocimem_b    = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            av_acc = (av_read || av_write) && !av_waitrequest;
            tick();
        end
        reset = 1'b0;
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        av_read = 1'b0; av_write = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
